xbar_port_requester: RTL and testbench

- Input-port front end of the crossbar: the requesting side of the round-robin output arbiters.
- Takes frames from its ingress FIFO and decodes the one-hot destination into a request to that output's arbiter.
- Holds the request for the whole frame, which keeps the arbiter's grant-hold engaged, and streams beats across the crossbar.
- Drops the request for exactly one cycle after the last beat so the arbiter can rotate priority.

---
 rtl/xbar_pkg.sv | 24 ++
 rtl/xbar_sat_counter.sv | 24 ++
 rtl/xbar_port_requester.sv | 149 ++++++++++++++
 tb/tb_xbar_port_requester.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar input-port requester.
package xbar_pkg;

  // Requester life cycle of one frame.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    GAP,
    DROP
  } xbar_req_state_e;

  // Default geometry of a crossbar port.
  localparam int P_PORTS  = 3;
  localparam int P_DATA_W = 8;
  localparam int P_CNT_W  = 16;

  // True when exactly one bit is set. Port vectors are zero-extended into
  // a 32-bit word, so crossbars up to 32 ports are covered.
  function automatic logic onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/xbar_sat_counter.sv
// Saturating up-counter for requester statistics; clr_ni clears it on a clock edge.
module xbar_sat_counter #(
  parameter int P_CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               clr_ni,
  input  logic               inc_i,
  output logic [P_CNT_W-1:0] cnt_o
);

  logic [P_CNT_W-1:0] cnt_q;

  // Count up on inc_i and stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {P_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xbar_port_requester.sv
// Crossbar input-port front end: decodes the frame destination, requests the
// matching output arbiter for the whole frame, streams beats while granted
// and releases the request for one cycle after the last beat.
module xbar_port_requester #(
  parameter int P_PORTS   = xbar_pkg::P_PORTS,
  parameter int P_DATA_W  = xbar_pkg::P_DATA_W,
  parameter int P_TIMEOUT = 256,
  parameter int P_CNT_W   = xbar_pkg::P_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [P_DATA_W-1:0] in_data_i,
  input  logic                in_last_i,
  input  logic [P_PORTS-1:0]  in_dest_i,
  output logic [P_PORTS-1:0]  request_o,
  input  logic [P_PORTS-1:0]  grant_i,
  output logic                xbar_valid_o,
  input  logic                xbar_ready_i,
  output logic [P_DATA_W-1:0] xbar_data_o,
  output logic                xbar_last_o,
  output logic [P_PORTS-1:0]  xbar_sel_o,
  output logic                drop_o,
  output logic                grant_lost_o,
  output logic [P_CNT_W-1:0]  fwd_cnt_o,
  output logic [P_CNT_W-1:0]  drop_cnt_o
);

  import xbar_pkg::*;

  // Watchdog only needs to reach P_TIMEOUT-1; keep at least one bit so the
  // disabled configuration still elaborates.
  localparam int WD_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

  xbar_req_state_e   state_q, state_d;
  logic [P_PORTS-1:0] dest_q, dest_d;
  logic [P_PORTS-1:0] request_q, request_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               granted_q, granted_d;
  logic               granted;
  logic               fwd_inc;

  assign granted = |(grant_i & dest_q);

  // Next-state decode plus the handshake and pulse outputs of each state.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    wd_d         = wd_q;
    in_ready_o   = 1'b0;
    xbar_valid_o = 1'b0;
    drop_o       = 1'b0;
    grant_lost_o = 1'b0;
    fwd_inc      = 1'b0;
    case (state_q)
      // GAP already spent its one idle request cycle, so it decodes a
      // waiting head beat exactly like IDLE; this keeps back-to-back frames
      // separated by a single low request cycle.
      IDLE, GAP: begin
        state_d = IDLE;
        if (in_valid_i) begin
          dest_d = in_dest_i;
          if (onehot(32'(in_dest_i))) begin
            state_d = REQ;
            wd_d    = '0;
          end else begin
            state_d = DROP;
            drop_o  = 1'b1;
          end
        end
      end
      REQ: begin
        if (P_TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
        if (granted) begin
          state_d = XFER;
        end else if ((P_TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          state_d = DROP;
          drop_o  = 1'b1;
        end
      end
      XFER: begin
        xbar_valid_o = in_valid_i & granted;
        in_ready_o   = xbar_ready_i & granted;
        grant_lost_o = granted_q & ~granted;
        if (in_valid_i && in_ready_o && in_last_i) begin
          state_d = GAP;
          fwd_inc = 1'b1;
        end
      end
      DROP: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered request follows the next state so it is glitch-free into the
  // arbiters; grant history is seeded high on entry because the entering
  // cycle was itself granted.
  always_comb begin
    request_d = ((state_d == REQ) || (state_d == XFER)) ? dest_d : '0;
    granted_d = (state_q == XFER) ? granted : 1'b1;
  end

  // State, destination, watchdog and request registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      wd_q      <= '0;
      request_q <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      wd_q      <= wd_d;
      request_q <= request_d;
      granted_q <= granted_d;
    end
  end

  assign request_o   = request_q;
  assign xbar_data_o = in_data_i;
  assign xbar_last_o = in_last_i;
  assign xbar_sel_o  = (state_q == XFER) ? dest_q : '0;

  xbar_sat_counter #(.P_CNT_W(P_CNT_W)) u_fwd_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_ni),
    .inc_i  (fwd_inc),
    .cnt_o  (fwd_cnt_o)
  );

  // Every entry into DROP is announced by drop_o, so it doubles as the increment.
  xbar_sat_counter #(.P_CNT_W(P_CNT_W)) u_drop_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_ni),
    .inc_i  (drop_o),
    .cnt_o  (drop_cnt_o)
  );

endmodule

// File: tb/tb_xbar_port_requester.sv
// Directed and randomized bench for xbar_port_requester with a frame-level model.
module tb_xbar_port_requester;

  localparam int NP = 3;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          in_last_i;
  logic [NP-1:0] in_dest_i;
  logic [NP-1:0] request_o;
  logic [NP-1:0] grant_i;
  logic          xbar_valid_o;
  logic          xbar_ready_i;
  logic [DW-1:0] xbar_data_o;
  logic          xbar_last_o;
  logic [NP-1:0] xbar_sel_o;
  logic          drop_o;
  logic          grant_lost_o;
  logic [CW-1:0] fwd_cnt_o;
  logic [CW-1:0] drop_cnt_o;

  xbar_port_requester #(
    .P_PORTS(NP), .P_DATA_W(DW), .P_TIMEOUT(TO), .P_CNT_W(CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .in_dest_i    (in_dest_i),
    .request_o    (request_o),
    .grant_i      (grant_i),
    .xbar_valid_o (xbar_valid_o),
    .xbar_ready_i (xbar_ready_i),
    .xbar_data_o  (xbar_data_o),
    .xbar_last_o  (xbar_last_o),
    .xbar_sel_o   (xbar_sel_o),
    .drop_o       (drop_o),
    .grant_lost_o (grant_lost_o),
    .fwd_cnt_o    (fwd_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [NP-1:0] dest;
  } beat_t;

  beat_t src_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [NP-1:0] req_hist[$];
  logic [DW-1:0] stall_data[$];

  int errors = 0;
  int checks = 0;
  int exp_fwd = 0;
  int exp_drop = 0;

  int drop_pulses, glost, xv_cycles, req_nz, drop_run, stall_bad;
  int req_run = 0;
  int grant_from = 0;
  int grant_off = 0;
  int ready_off = 0;
  bit grant_rand = 0;
  bit ready_rand = 0;
  bit valid_rand = 0;
  bit watch_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic clear_win();
    drop_pulses = 0; glost = 0; xv_cycles = 0; req_nz = 0;
    drop_run = -1; stall_bad = 0;
    req_hist.delete(); stall_data.delete();
  endtask

  // Queue a frame at the source; the model decides its fate from the dest
  // rule unless the caller knows the frame will time out.
  task automatic push_frame(input logic [NP-1:0] dest, input int n, input int base, input bit force_drop);
    bit fwd;
    fwd = ($countones(dest) == 1) && !force_drop;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = DW'(base + i);
      b.last = (i == n - 1);
      b.dest = dest;
      src_q.push_back(b);
      if (fwd) exp_q.push_back(b);
    end
    if (fwd) exp_fwd++; else exp_drop++;
  endtask

  // One clock: sample outputs at the falling edge, then drive the next cycle.
  task automatic tick();
    bit acc;
    bit g;
    @(negedge clk);
    if (drop_o) begin
      drop_pulses++;
      if (request_o != '0) drop_run = req_run;
    end
    if (grant_lost_o) glost++;
    if (xbar_valid_o) xv_cycles++;
    if (request_o != '0) req_nz++;
    req_hist.push_back(request_o);
    if (xbar_valid_o && xbar_ready_i) begin
      beat_t b;
      b.data = xbar_data_o; b.last = xbar_last_o; b.dest = xbar_sel_o;
      obs_q.push_back(b);
    end
    if (watch_stall && xbar_valid_o && !xbar_ready_i) begin
      stall_data.push_back(xbar_data_o);
      if (in_ready_o) stall_bad++;
    end
    acc = in_valid_i && in_ready_o;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    if (src_q.size() == 0) in_valid_i = 1'b0;
    else if (!(in_valid_i && !acc)) in_valid_i = valid_rand ? ($urandom_range(3) != 0) : 1'b1;
    if (src_q.size() != 0) begin
      in_data_i = src_q[0].data; in_last_i = src_q[0].last; in_dest_i = src_q[0].dest;
    end else begin
      in_data_i = '0; in_last_i = 1'b0; in_dest_i = '0;
    end
    if (ready_off > 0) begin
      xbar_ready_i = 1'b0; ready_off--;
    end else begin
      xbar_ready_i = ready_rand ? 1'($urandom_range(1)) : 1'b1;
    end
    if (request_o != '0) req_run++; else req_run = 0;
    if (grant_rand) g = ($urandom_range(2) != 0) || (req_run >= 8);
    else if (grant_from == 0) g = 1'b1;
    else if (grant_from < 0) g = 1'b0;
    else g = (req_run >= grant_from);
    if (grant_off > 0 && xbar_sel_o != '0) begin
      g = 1'b0; grant_off--;
    end
    grant_i = g ? request_o : '0;
  endtask

  task automatic run_drain(input string tag, input int bound);
    int n = 0;
    while (src_q.size() != 0 && n < bound) begin
      tick(); n++;
    end
    chk({tag, "_drained"}, src_q.size(), 0);
    src_q.delete();
    repeat (3) tick();
  endtask

  task automatic run_until_obs(input string tag, input int nb, input int bound);
    int n = 0;
    while (obs_q.size() < nb && n < bound) begin
      tick(); n++;
    end
    chk({tag, "_reached"}, (obs_q.size() >= nb), 1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      chk({tag, "_last"}, obs_q[i].last, exp_q[i].last);
      chk({tag, "_sel"}, obs_q[i].dest, exp_q[i].dest);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_fwd_cnt"}, fwd_cnt_o, sat(exp_fwd));
    chk({tag, "_drop_cnt"}, drop_cnt_o, sat(exp_drop));
  endtask

  initial begin
    int n_gaps, min_gap, max_gap, zrun, wrong;
    bit seen;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    in_dest_i = '0; grant_i = '0; xbar_ready_i = 1'b1;
    clear_win();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_request", request_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_xvalid", xbar_valid_o, 0);
    chk("rst_sel", xbar_sel_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_glost", grant_lost_o, 0);
    check_counts("rst");
    @(posedge clk); #1; rst_ni = 1'b1;

    // 4-beat frame to port 1 with grant always on.
    clear_win(); grant_from = 0;
    push_frame(3'b010, 4, 8'hA0, 0);
    run_drain("t1", 200);
    check_beats("t1");
    chk("t1_req_cycles", req_nz, 5);
    wrong = 0;
    foreach (req_hist[i]) if (req_hist[i] != '0 && req_hist[i] != 3'b010) wrong++;
    chk("t1_req_value", wrong, 0);
    chk("t1_drops", drop_pulses, 0);
    check_counts("t1");

    // Zero and multi-hot destinations are consumed and dropped.
    clear_win();
    push_frame(3'b000, 3, 8'h10, 0);
    push_frame(3'b011, 3, 8'h20, 0);
    run_drain("t2", 200);
    chk("t2_req_cycles", req_nz, 0);
    chk("t2_xvalid_cycles", xv_cycles, 0);
    chk("t2_drops", drop_pulses, 2);
    check_beats("t2");
    check_counts("t2");

    // Watchdog: no grant drops on the 16th REQ cycle; grant on the 15th wins.
    clear_win(); grant_from = -1;
    push_frame(3'b100, 5, 8'h30, 1);
    run_drain("t3a", 200);
    chk("t3a_drops", drop_pulses, 1);
    chk("t3a_drop_req_cycle", drop_run, TO);
    check_beats("t3a");
    check_counts("t3a");
    clear_win(); grant_from = TO - 1;
    push_frame(3'b100, 3, 8'h40, 0);
    run_drain("t3b", 200);
    chk("t3b_drops", drop_pulses, 0);
    check_beats("t3b");
    check_counts("t3b");

    // Back-to-back frames: one low request cycle between them.
    clear_win(); grant_from = 0;
    push_frame(3'b001, 3, 8'h60, 0);
    push_frame(3'b001, 3, 8'h70, 0);
    run_drain("t4", 200);
    n_gaps = 0; min_gap = 1000; max_gap = 0; zrun = 0; seen = 0;
    foreach (req_hist[i]) begin
      if (req_hist[i] != '0) begin
        if (seen && zrun > 0) begin
          n_gaps++;
          if (zrun < min_gap) min_gap = zrun;
          if (zrun > max_gap) max_gap = zrun;
        end
        seen = 1; zrun = 0;
      end else begin
        zrun++;
      end
    end
    chk("t4_gaps", n_gaps, 1);
    chk("t4_gap_min", min_gap, 1);
    chk("t4_gap_max", max_gap, 1);
    check_beats("t4");
    check_counts("t4");

    // Backpressure for 5 cycles, then grant withdrawn for 2 cycles.
    clear_win();
    push_frame(3'b010, 8, 8'h80, 0);
    run_until_obs("t5_mid", 3, 200);
    ready_off = 5; watch_stall = 1;
    repeat (6) tick();
    watch_stall = 0;
    chk("t5_stall_cycles", stall_data.size(), 5);
    wrong = 0;
    foreach (stall_data[i]) if (stall_data[i] !== stall_data[0]) wrong++;
    chk("t5_stall_data_stable", wrong, 0);
    chk("t5_stall_in_ready", stall_bad, 0);
    grant_off = 2;
    run_drain("t5", 200);
    chk("t5_grant_lost", glost, 1);
    check_beats("t5");
    check_counts("t5");

    // Reset during XFER abandons the frame and clears everything.
    clear_win();
    push_frame(3'b100, 6, 8'h90, 0);
    run_until_obs("t6_mid", 2, 200);
    chk("t6_in_xfer", xbar_sel_o, 3'b100);
    rst_ni = 1'b0;
    src_q.delete(); exp_q.delete(); obs_q.delete();
    in_valid_i = 1'b0; in_last_i = 1'b0; in_dest_i = '0;
    exp_fwd = 0; exp_drop = 0;
    @(posedge clk); #1;
    rst_ni = 1'b1; grant_i = '0;
    @(negedge clk);
    chk("t6_request", request_o, 0);
    chk("t6_xvalid", xbar_valid_o, 0);
    chk("t6_in_ready", in_ready_o, 0);
    chk("t6_sel", xbar_sel_o, 0);
    check_counts("t6");

    // Randomized traffic with random valid, ready and grant behaviour.
    clear_win(); valid_rand = 1; ready_rand = 1; grant_rand = 1;
    for (int f = 0; f < 12; f++) begin
      logic [NP-1:0] d;
      if ($urandom_range(3) != 0) d = NP'(1 << $urandom_range(NP - 1));
      else d = NP'($urandom_range(7));
      push_frame(d, $urandom_range(1, 5), $urandom_range(255), 0);
    end
    run_drain("rnd", 3000);
    chk("rnd_drops", drop_pulses, exp_drop);
    check_beats("rnd");
    check_counts("rnd");
    valid_rand = 0; ready_rand = 0; grant_rand = 0;

    // Single-beat frames push both counters into saturation.
    clear_win();
    for (int f = 0; f < CMAX + 3; f++) begin
      push_frame(3'b001, 1, f, 0);
      push_frame(3'b000, 1, f, 0);
    end
    run_drain("sat", 3000);
    check_beats("sat");
    check_counts("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
